// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue instruction buffer between the instruction ROM and
// decode. Up to two {addr,instr} pairs enter per cycle (slot 0 ahead of slot
// 1); the two oldest entries are presented to decode, which may take 0, 1
// or 2 of them in order. flush discards the whole contents at the next edge.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   flush                    drop all entries at the next edge
//   in_valid[1:0]            per-slot valid from the ROM
//   in_addr_0/1, in_instr_0/1  incoming entries, slot 0 is older
//   in_ready                 queue can take two entries this cycle
//   out_valid[1:0]           [0] oldest entry valid, [1] next oldest valid
//   out_addr_0/1, out_instr_0/1  two oldest entries, zero when not valid
//   out_ready[1:0]           decode takes slot 0 / slot 1
//   count                    current occupancy
//
// Optional feature (macro FETCH_QUEUE_STATS_EN):
//   stall_cycles[31:0]       saturating count of cycles where fetch offered
//                            data while the queue could not take it
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [1:0]                   in_valid,
    input  logic [ADDR_WIDTH-1:0]        in_addr_0,
    input  logic [ADDR_WIDTH-1:0]        in_addr_1,
    input  logic [DATA_WIDTH-1:0]        in_instr_0,
    input  logic [DATA_WIDTH-1:0]        in_instr_1,
    output logic                         in_ready,
    output logic [1:0]                   out_valid,
    output logic [ADDR_WIDTH-1:0]        out_addr_0,
    output logic [ADDR_WIDTH-1:0]        out_addr_1,
    output logic [DATA_WIDTH-1:0]        out_instr_0,
    output logic [DATA_WIDTH-1:0]        out_instr_1,
    input  logic [1:0]                   out_ready,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [31:0]                  stall_cycles,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] addr_mem_r  [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];

    logic [PW-1:0] head_r, tail_r;
    logic [CW-1:0] count_r;

    logic [PW-1:0] head_next_s, tail_next_s;
    logic [CW-1:0] count_next_s;
    logic          in_ready_s;
    logic          valid0_s, valid1_s;
    logic          wr0_s, wr1_s;
    logic [PW-1:0] wr1_idx_s;
    logic [PW-1:0] rd1_idx_s;
    logic          pop0_s, pop1_s;
    logic [1:0]    push_cnt_s, pop_cnt_s;

    // Handshake decode: room for two is judged on registered count only.
    always_comb begin
        in_ready_s = (count_r <= CW'(DEPTH - 2));
        valid0_s   = (count_r != {CW{1'b0}});
        valid1_s   = (count_r >= CW'(2));
        wr0_s      = in_ready_s & ~flush & in_valid[0];
        wr1_s      = in_ready_s & ~flush & in_valid[1];
        // A lone slot-1 entry lands at tail, otherwise right behind slot 0.
        if (in_valid[0]) begin
            wr1_idx_s = tail_r + PW'(1'b1);
        end else begin
            wr1_idx_s = tail_r;
        end
        rd1_idx_s  = head_r + PW'(1'b1);
        pop0_s     = valid0_s & out_ready[0];
        // Slot 1 can only leave together with slot 0 to keep FIFO order.
        pop1_s     = pop0_s & valid1_s & out_ready[1];
        push_cnt_s = {1'b0, wr0_s} + {1'b0, wr1_s};
        pop_cnt_s  = {1'b0, pop0_s} + {1'b0, pop1_s};
    end

    // Next pointer/occupancy; flush overrides any push or pop.
    always_comb begin
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        if (flush) begin
            head_next_s  = {PW{1'b0}};
            tail_next_s  = {PW{1'b0}};
            count_next_s = {CW{1'b0}};
        end else begin
            head_next_s  = head_r + PW'(pop_cnt_s);
            tail_next_s  = tail_r + PW'(push_cnt_s);
            count_next_s = count_r + CW'(push_cnt_s) - CW'(pop_cnt_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
        end
    end

    // Entry storage; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr0_s) begin
            addr_mem_r[tail_r]  <= in_addr_0;
            instr_mem_r[tail_r] <= in_instr_0;
        end
        if (wr1_s) begin
            addr_mem_r[wr1_idx_s]  <= in_addr_1;
            instr_mem_r[wr1_idx_s] <= in_instr_1;
        end
    end

    // Output presentation: invalid slots are driven to zero.
    always_comb begin
        out_valid = {valid1_s, valid0_s};
        in_ready  = in_ready_s;
        count     = count_r;
        if (valid0_s) begin
            out_addr_0  = addr_mem_r[head_r];
            out_instr_0 = instr_mem_r[head_r];
        end else begin
            out_addr_0  = {ADDR_WIDTH{1'b0}};
            out_instr_0 = {DATA_WIDTH{1'b0}};
        end
        if (valid1_s) begin
            out_addr_1  = addr_mem_r[rd1_idx_s];
            out_instr_1 = instr_mem_r[rd1_idx_s];
        end else begin
            out_addr_1  = {ADDR_WIDTH{1'b0}};
            out_instr_1 = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cycles_r;

    // Saturating count of cycles where fetch was blocked by a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if ((in_valid != 2'b00) && !in_ready_s && !flush &&
                     (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`endif

endmodule
